// File: rtl/insn_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response, decode handshake.
// master = fetch unit, slave = surrounding core/memory.
interface insn_fetch_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned INSN_WIDTH = 32
) ();
  logic                  redirect_valid;
  logic [WIDTH-1:0]      redirect_pc;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [WIDTH-1:0]      mem_req_addr;
  logic                  mem_rsp_valid;
  logic [INSN_WIDTH-1:0] mem_rsp_data;
  logic                  insn_valid;
  logic                  insn_ready;
  logic [INSN_WIDTH-1:0] insn_data;
  logic [WIDTH-1:0]      insn_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, insn_ready,
    output mem_req_valid, mem_req_addr, insn_valid, insn_data, insn_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, insn_ready,
    input  mem_req_valid, mem_req_addr, insn_valid, insn_data, insn_pc
  );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry {insn,pc} buffer, redirect flush.
// Define INSN_FETCH_SQUASH_CNT_EN to add the 16-bit saturating squash_count output.
module insn_fetch #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      INSN_WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         reset,
  insn_fetch_if.master bus
`ifdef INSN_FETCH_SQUASH_CNT_EN
  ,
  output logic [15:0]  squash_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]      pending_pc_q, pending_pc_d;
  logic [1:0]            count_q, count_d, count_pop;
  logic [INSN_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [WIDTH-1:0]      pc0_q, pc0_d, pc1_q, pc1_d;
  logic                  req_valid_q, req_valid_d;
  logic                  insn_valid_q, insn_valid_d;
  logic                  push, pop, squash;

  // Next state: redirect overrides everything, then the normal fetch loop.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    squash       = 1'b0;
    pop          = insn_valid_q & bus.insn_ready;
    count_pop    = count_q - 2'(pop);

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      case (state_q)
        S_REQ:   state_d = bus.mem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT,
        S_DRAIN: begin
          state_d = bus.mem_rsp_valid ? S_REQ : S_DRAIN;
          squash  = bus.mem_rsp_valid;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (count_pop < 2'd2) state_d = S_REQ;
        S_REQ: if (bus.mem_req_ready) begin
          state_d      = S_WAIT;
          pending_pc_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + WIDTH'(1);
        end
        S_WAIT: if (bus.mem_rsp_valid) begin
          push    = 1'b1;
          state_d = (count_pop == 2'd0) ? S_REQ : S_IDLE;
        end
        S_DRAIN: if (bus.mem_rsp_valid) begin
          squash  = 1'b1;
          state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Shift-style buffer: entry 0 is always the head so outputs come straight from flops.
    data0_d = pop ? data1_q : data0_q;
    pc0_d   = pop ? pc1_q   : pc0_q;
    data1_d = data1_q;
    pc1_d   = pc1_q;
    if (push) begin
      if (count_pop == 2'd0) begin
        data0_d = bus.mem_rsp_data;
        pc0_d   = pending_pc_q;
      end else begin
        data1_d = bus.mem_rsp_data;
        pc1_d   = pending_pc_q;
      end
    end
    count_d      = bus.redirect_valid ? 2'd0 : count_pop + 2'(push);
    insn_valid_d = (count_d != 2'd0);
    req_valid_d  = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      count_q      <= 2'd0;
      data0_q      <= '0;
      data1_q      <= '0;
      pc0_q        <= '0;
      pc1_q        <= '0;
      req_valid_q  <= 1'b0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      pc0_q        <= pc0_d;
      pc1_q        <= pc1_d;
      req_valid_q  <= req_valid_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.insn_valid    = insn_valid_q;
  assign bus.insn_data     = data0_q;
  assign bus.insn_pc       = pc0_q;

`ifdef INSN_FETCH_SQUASH_CNT_EN
  logic [15:0] squash_cnt_q;

  // Discarded responses, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash_cnt_q <= 16'd0;
    end else if (squash && (squash_cnt_q != 16'hFFFF)) begin
      squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign squash_count = squash_cnt_q;
`else
  logic squash_unused;
  assign squash_unused = squash;
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: directed scenarios plus random traffic against a transaction-level
// model (expected pc stream, memory with one pending response, flush on redirect).
module tb_insn_fetch;
  localparam int unsigned      W      = 32;
  localparam int unsigned      IW     = 32;
  localparam logic [W-1:0]     RST_PC = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;

  insn_fetch_if #(.WIDTH(W), .INSN_WIDTH(IW)) bus ();
`ifdef INSN_FETCH_SQUASH_CNT_EN
  logic [15:0] squash_count;
`endif

  insn_fetch #(.WIDTH(W), .INSN_WIDTH(IW), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef INSN_FETCH_SQUASH_CNT_EN
    ,
    .squash_count (squash_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_req_pc;
  bit           pend, pend_squash;
  logic [W-1:0] pend_addr;
  int           pend_wait;
  int unsigned  squash_model;
  int unsigned  p_rdy, p_ird, p_rd, dmin, dmax;
  bit           last_acc, rst_seen, armed;
  int unsigned  pops;

  function automatic logic [IW-1:0] memf(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_reset();
    check("rst_req_valid",  64'(bus.mem_req_valid), 64'd0);
    check("rst_insn_valid", 64'(bus.insn_valid),    64'd0);
    check("rst_insn_data",  64'(bus.insn_data),     64'd0);
    check("rst_insn_pc",    64'(bus.insn_pc),       64'd0);
    check("rst_req_addr",   64'(bus.mem_req_addr),  64'(RST_PC));
`ifdef INSN_FETCH_SQUASH_CNT_EN
    check("rst_squash_count", 64'(squash_count), 64'd0);
`endif
  endtask

  // One clock: check outputs, capture events, advance edge, update model, drive next inputs.
  task automatic tick();
    bit acc, rsp, pop, rd, rs;
    logic [W-1:0] rd_pc;
    if (armed) begin
      if (rst_seen) chk_reset();
      else begin
        check("insn_valid", 64'(bus.insn_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("insn_pc",   64'(bus.insn_pc),   64'(exp_q[0]));
          check("insn_data", 64'(bus.insn_data), 64'(memf(exp_q[0])));
        end
        if (bus.mem_req_valid) begin
          check("req_addr",        64'(bus.mem_req_addr), 64'(exp_req_pc));
          check("one_outstanding", 64'(pend),             64'd0);
          check("buffer_room",     64'(exp_q.size() < 2), 64'd1);
        end
`ifdef INSN_FETCH_SQUASH_CNT_EN
        check("squash_count", 64'(squash_count), 64'(squash_model));
`endif
      end
    end
    acc   = bus.mem_req_valid && bus.mem_req_ready;
    rsp   = bus.mem_rsp_valid;
    pop   = bus.insn_valid && bus.insn_ready;
    rd    = bus.redirect_valid;
    rd_pc = bus.redirect_pc;
    rs    = reset;
    @(posedge clk);
    #1;
    rst_seen = rs;
    last_acc = 1'b0;
    if (rs) begin
      exp_q.delete();
      exp_req_pc   = RST_PC;
      pend         = 1'b0;
      squash_model = 0;
    end else begin
      if (pop && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (rsp && pend) begin
        if (pend_squash || rd) squash_model++;
        else exp_q.push_back(pend_addr);
        pend = 1'b0;
      end else if (pend) begin
        pend_wait--;
        if (rd) pend_squash = 1'b1;
      end
      if (acc) begin
        last_acc    = 1'b1;
        pend        = 1'b1;
        pend_addr   = exp_req_pc;
        pend_squash = rd;
        pend_wait   = int'($urandom_range(dmax, dmin)) - 1;
        exp_req_pc  = exp_req_pc + W'(1);
      end
      if (rd) begin
        exp_q.delete();
        exp_req_pc = rd_pc;
      end
    end
    bus.redirect_valid = !rd && (p_rd != 0) && ($urandom_range(99, 0) < p_rd);
    bus.redirect_pc    = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
    bus.mem_req_ready  = $urandom_range(99, 0) < p_rdy;
    bus.insn_ready     = $urandom_range(99, 0) < p_ird;
    if (reset) begin
      bus.mem_rsp_valid = 1'($urandom_range(1, 0));
      bus.mem_rsp_data  = $urandom;
    end else begin
      bus.mem_rsp_valid = pend && (pend_wait == 0);
      bus.mem_rsp_data  = pend ? memf(pend_addr) : $urandom;
    end
  endtask

  task automatic wait_acc();
    int n = 0;
    tick();
    while (!last_acc && n < 20) begin
      tick();
      n++;
    end
    check("acc_timeout", 64'(last_acc), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold_pc;
    int n;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.insn_ready     = 1'b1;
    p_rdy = 100; p_ird = 100; p_rd = 0; dmin = 1; dmax = 1;
    pend = 1'b0; pend_squash = 1'b0; pend_addr = '0; pend_wait = 0;
    exp_req_pc = RST_PC; squash_model = 0; pops = 0;
    rst_seen = 1'b0; armed = 1'b0; last_acc = 1'b0;

    // Reset hold, with stray memory responses that must be ignored
    tick();
    armed = 1'b1;
    repeat (3) tick();

    // Release: first request at RESET_PC, then one instruction per two cycles with wrap
    reset = 1'b0;
    tick();
    check("first_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("first_req_addr",  64'(bus.mem_req_addr),  64'(RST_PC));
    for (int k = 0; k < 9; k++) begin
      if (k >= 2 && k % 2 == 0) begin
        check("cadence_valid", 64'(bus.insn_valid), 64'd1);
        check("cadence_pc",    64'(bus.insn_pc),    64'(W'(RST_PC + W'(k / 2 - 1))));
      end else begin
        check("cadence_gap", 64'(bus.insn_valid), 64'd0);
      end
      tick();
    end

    // Decode stalled: buffer fills to two, no further requests; resume at head+2
    p_ird = 0;
    bus.insn_ready = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      check("stall_req_valid",  64'(bus.mem_req_valid), 64'd0);
      check("stall_insn_valid", 64'(bus.insn_valid),    64'd1);
      tick();
    end
    hold_pc = exp_q[0];
    p_ird = 100;
    bus.insn_ready = 1'b1;
    n = 0;
    tick();
    while (!bus.mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    check("resume_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("resume_addr",      64'(bus.mem_req_addr),  64'(W'(hold_pc + W'(2))));

    // Redirect while waiting on a slow response: response dropped, 0x100 fetched next
    dmin = 3; dmax = 3;
    wait_acc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    check("redir_wait_flush", 64'(bus.insn_valid), 64'd0);
    n = 0;
    while (!bus.insn_valid && n < 20) begin
      tick();
      n++;
    end
    check("redir_wait_valid", 64'(bus.insn_valid), 64'd1);
    check("redir_wait_pc",    64'(bus.insn_pc),    64'h100);
    check("redir_wait_data",  64'(bus.insn_data),  64'(memf(32'h100)));
`ifdef INSN_FETCH_SQUASH_CNT_EN
    check("redir_wait_squash", 64'(squash_count), 64'd1);
`endif

    // Redirect in the same cycle as the response
    dmin = 1; dmax = 1;
    wait_acc();
    check("redir_rsp_present", 64'(bus.mem_rsp_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    check("redir_rsp_insn_valid", 64'(bus.insn_valid),    64'd0);
    check("redir_rsp_req_valid",  64'(bus.mem_req_valid), 64'd1);
    check("redir_rsp_addr",       64'(bus.mem_req_addr),  64'h40);

    // Reset while a request is outstanding
    dmin = 3; dmax = 3;
    wait_acc();
    reset = 1'b1;
    tick();
    chk_reset();
    tick();
    reset = 1'b0;
    tick();
    check("rerst_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("rerst_req_addr",  64'(bus.mem_req_addr),  64'(RST_PC));

    // Random traffic phases
    for (int ph = 0; ph < 4; ph++) begin
      p_rdy = $urandom_range(100, 30);
      p_ird = $urandom_range(100, 20);
      p_rd  = $urandom_range(15, 2);
      dmin  = 1;
      dmax  = $urandom_range(4, 1);
      pops  = 0;
      repeat (600) tick();
      check("progress", 64'(pops > 0), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 Parameter WIDTH, default 32: PC/address width in bits.
REQ-002 Parameter INSN_WIDTH, default 32: instruction word width.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 One clock and one reset; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
REQ-008 redirect_pc  in  WIDTH  redirect target, valid when redirect_valid=1.
REQ-009 mem_req_valid  out  1  fetch request to instruction memory.
REQ-010 mem_req_ready  in  1  memory accepts request when valid&ready.
REQ-011 mem_req_addr  out  WIDTH  word address of request.
REQ-012 mem_rsp_valid  in  1  response strobe, exactly one per accepted request, in order, always accepted.
REQ-013 mem_rsp_data  in  INSN_WIDTH  fetched instruction word.
REQ-014 insn_valid  out  1  instruction available to decode.
REQ-015 insn_ready  in  1  decode consumes when insn_valid&insn_ready.
REQ-016 insn_data  out  INSN_WIDTH  instruction word at buffer head.
REQ-017 insn_pc  out  WIDTH  address of insn_data.

Function
REQ-018 fetch_pc register holds next address to request; increments by 1 (word-addressed) on each accepted request, wrapping 2^WIDTH-1 -> 0.
REQ-019 At most one request outstanding; 2-entry FIFO buffers {insn_data, insn_pc}.
REQ-020 States: IDLE, REQ, WAIT, DRAIN; IDLE -> REQ when buffer count + outstanding < 2.
REQ-021 REQ: mem_req_valid=1, mem_req_addr=fetch_pc; on mem_req_ready -> WAIT, pending_pc <= fetch_pc.
REQ-022 WAIT: on mem_rsp_valid push {mem_rsp_data, pending_pc}; -> REQ if post-push/pop count < 2, else IDLE.
REQ-023 DRAIN: mem_req_valid=0; on mem_rsp_valid discard response -> REQ.
REQ-024 insn_valid = FIFO non-empty (registered); pop on insn_valid&insn_ready; push and pop in same cycle keep count.
REQ-025 Response in cycle N -> insn_valid=1 in cycle N+1 when FIFO was empty.
REQ-026 Redirect has highest priority: FIFO flushed (insn_valid=0 next cycle), fetch_pc <= redirect_pc.
REQ-027 Redirect in REQ with mem_req_ready=1, or in WAIT without mem_rsp_valid -> DRAIN.
REQ-028 Redirect in WAIT with same-cycle mem_rsp_valid -> response discarded, -> REQ.
REQ-029 Redirect in REQ without mem_req_ready, or in IDLE -> REQ; mem_req_addr=redirect_pc next cycle.
REQ-030 Redirect in DRAIN -> fetch_pc updated, stay DRAIN; only latest redirect target fetched.
REQ-031 mem_req_addr stable while mem_req_valid=1 and not accepted, except on the cycle after a redirect.

Reset
REQ-032 During reset: mem_req_valid=0, insn_valid=0, insn_data=0, insn_pc=0, mem_req_addr=RESET_PC, FIFO empty, state IDLE, fetch_pc=RESET_PC.
REQ-033 First cycle after reset deassertion: mem_req_valid=1, mem_req_addr=RESET_PC.
REQ-034 Reset mid-operation abandons outstanding request; memory shares this reset, responses during reset ignored.

Configuration
REQ-035 Macro INSN_FETCH_SQUASH_CNT_EN defined: output squash_count (16 bits) counts discarded responses (DRAIN and REQ-028), saturates at 0xFFFF, reset to 0.
REQ-036 Macro undefined: squash_count port and counter absent; all other behaviour identical.

Verification
REQ-037 Reset release, memory always ready, 1-cycle response, insn_ready=1 -> insn_pc 0,1,2,3 with matching data, one instruction per two cycles.
REQ-038 insn_ready=0 -> exactly two instructions buffered, mem_req_valid stays 0; insn_ready=1 -> fetch resumes at pc 2.
REQ-039 Redirect to 0x100 while WAIT for pc 5 -> pc 5 response dropped, next insn_pc=0x100, squash_count=1 (macro on).
REQ-040 Redirect to 0x40 same cycle as response -> response dropped, next request addr 0x40, no stale insn_valid.
REQ-041 RESET_PC=0xFFFFFFFF -> fetch order 0xFFFFFFFF, 0x0, 0x1.
REQ-042 Reset asserted in WAIT -> next cycle all outputs at reset values; after release first request addr=RESET_PC.
